// File: rtl/morse_keyer.sv
// Morse keyer: accepts one A-Z/0-9 code per handshake and keys its ITU pattern.
// Optional word-space code 36 is enabled by defining MORSE_WORD_SPACE_EN.
module morse_keyer #(
  parameter int UNIT_CYCLES    = 4,
  parameter int DASH_UNITS     = 3,
  parameter int ELEM_GAP_UNITS = 1,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] num,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       ponto,
  output logic       traco,
  output logic [2:0] elem_idx,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    EGAP,
    CGAP
  } state_t;

  localparam int M1 = (DASH_UNITS > ELEM_GAP_UNITS) ?
                      DASH_UNITS : ELEM_GAP_UNITS;
  localparam int M2 = (M1 > CHAR_GAP_UNITS) ? M1 : CHAR_GAP_UNITS;
  localparam int MAXU = (M2 > WORD_GAP_UNITS) ? M2 : WORD_GAP_UNITS;
  localparam int UW = (MAXU > 1) ? $clog2(MAXU) : 1;
  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  // {len, pattern}: pattern is left-aligned, bit 4 is the first element,
  // 1 = dot, 0 = dash; len 0 marks an unsupported code
  function automatic logic [7:0] lookup(input logic [5:0] c);
    logic [7:0] r;
    case (c)
      6'd0:  r = {3'd2, 5'b10000};
      6'd1:  r = {3'd4, 5'b01110};
      6'd2:  r = {3'd4, 5'b01010};
      6'd3:  r = {3'd3, 5'b01100};
      6'd4:  r = {3'd1, 5'b10000};
      6'd5:  r = {3'd4, 5'b11010};
      6'd6:  r = {3'd3, 5'b00100};
      6'd7:  r = {3'd4, 5'b11110};
      6'd8:  r = {3'd2, 5'b11000};
      6'd9:  r = {3'd4, 5'b10000};
      6'd10: r = {3'd3, 5'b01000};
      6'd11: r = {3'd4, 5'b10110};
      6'd12: r = {3'd2, 5'b00000};
      6'd13: r = {3'd2, 5'b01000};
      6'd14: r = {3'd3, 5'b00000};
      6'd15: r = {3'd4, 5'b10010};
      6'd16: r = {3'd4, 5'b00100};
      6'd17: r = {3'd3, 5'b10100};
      6'd18: r = {3'd3, 5'b11100};
      6'd19: r = {3'd1, 5'b00000};
      6'd20: r = {3'd3, 5'b11000};
      6'd21: r = {3'd4, 5'b11100};
      6'd22: r = {3'd3, 5'b10000};
      6'd23: r = {3'd4, 5'b01100};
      6'd24: r = {3'd4, 5'b01000};
      6'd25: r = {3'd4, 5'b00110};
      6'd26: r = {3'd5, 5'b00000};
      6'd27: r = {3'd5, 5'b10000};
      6'd28: r = {3'd5, 5'b11000};
      6'd29: r = {3'd5, 5'b11100};
      6'd30: r = {3'd5, 5'b11110};
      6'd31: r = {3'd5, 5'b11111};
      6'd32: r = {3'd5, 5'b01111};
      6'd33: r = {3'd5, 5'b00111};
      6'd34: r = {3'd5, 5'b00011};
      6'd35: r = {3'd5, 5'b00001};
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  state_t          state;
  logic [CW-1:0]   cyc;
  logic [UW-1:0]   units;
  logic [UW-1:0]   last_u;
  logic [4:0]      pat;
  logic [2:0]      len;
  logic [7:0]      code;
  logic            tick;
  logic            phase_end;
  logic            space;

  assign code      = lookup(num);
  assign tick      = (cyc == CW'(UNIT_CYCLES - 1));
  assign phase_end = tick && (units == last_u);
`ifdef MORSE_WORD_SPACE_EN
  assign space     = (num == 6'd36);
`else
  assign space     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cyc      <= '0;
      units    <= '0;
      last_u   <= '0;
      pat      <= '0;
      len      <= '0;
      in_ready <= 1'b1;
      tx       <= 1'b0;
      ponto    <= 1'b0;
      traco    <= 1'b0;
      elem_idx <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state != IDLE) begin
        if (tick) begin
          cyc   <= '0;
          units <= (units == last_u) ? '0 : units + 1'b1;
        end else begin
          cyc <= cyc + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            cyc      <= '0;
            units    <= '0;
            elem_idx <= '0;
            if (code[7:5] != 3'd0) begin
              state    <= MARK;
              len      <= code[7:5];
              pat      <= code[4:0];
              in_ready <= 1'b0;
              tx       <= 1'b1;
              ponto    <= code[4];
              traco    <= ~code[4];
              last_u   <= code[4] ? '0 : UW'(DASH_UNITS - 1);
            end else if (space) begin
              state    <= CGAP;
              in_ready <= 1'b0;
              last_u   <= UW'(WORD_GAP_UNITS - 1);
            end else begin
              err <= 1'b1;
            end
          end
        end
        MARK: begin
          if (phase_end) begin
            tx    <= 1'b0;
            ponto <= 1'b0;
            traco <= 1'b0;
            if (elem_idx == len - 3'd1) begin
              state  <= CGAP;
              last_u <= UW'(CHAR_GAP_UNITS - 1);
            end else begin
              state  <= EGAP;
              last_u <= UW'(ELEM_GAP_UNITS - 1);
            end
          end
        end
        EGAP: begin
          if (phase_end) begin
            state    <= MARK;
            pat      <= {pat[3:0], 1'b0};
            elem_idx <= elem_idx + 3'd1;
            tx       <= 1'b1;
            ponto    <= pat[3];
            traco    <= ~pat[3];
            last_u   <= pat[3] ? '0 : UW'(DASH_UNITS - 1);
          end
        end
        CGAP: begin
          if (phase_end) begin
            state    <= IDLE;
            done     <= 1'b1;
            in_ready <= 1'b1;
            elem_idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer: model expands dot/dash strings into
// per-cycle traces; a monitor records the DUT trace and compares on done/err.
module tb_morse_keyer;

  localparam int UC = 4;
  localparam int DU = 3;
  localparam int EG = 1;
  localparam int CG = 3;
  localparam int WG = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] num = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       ponto;
  logic       traco;
  logic [2:0] elem_idx;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  morse_keyer #(
    .UNIT_CYCLES(UC),
    .DASH_UNITS(DU),
    .ELEM_GAP_UNITS(EG),
    .CHAR_GAP_UNITS(CG),
    .WORD_GAP_UNITS(WG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .num(num),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx(tx),
    .ponto(ponto),
    .traco(traco),
    .elem_idx(elem_idx),
    .done(done),
    .err(err)
  );

  typedef struct {
    bit    is_err;
    string sym;
    string idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  string mt[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
    ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
    "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  function automatic void add(inout exp_t e, input string s,
                              input int ix, input int n);
    for (int k = 0; k < n; k++) begin
      e.sym = {e.sym, s};
      e.idx = $sformatf("%s%0d", e.idx, ix);
    end
  endfunction

  function automatic exp_t model(int c);
    exp_t e;
    e.is_err = 1'b0;
    e.sym = "";
    e.idx = "";
    if (c < 36) begin
      int l;
      l = mt[c].len();
      for (int i = 0; i < l; i++) begin
        if (mt[c].getc(i) == 8'h2E) add(e, ".", i, UC);
        else add(e, "-", i, DU * UC);
        if (i < l - 1) add(e, "_", i, EG * UC);
      end
      add(e, "_", l - 1, CG * UC);
    end
`ifdef MORSE_WORD_SPACE_EN
    else if (c == 36) add(e, "_", 0, WG * UC);
`endif
    else e.is_err = 1'b1;
    return e;
  endfunction

  task automatic chk(string name, bit ok, string act, string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%s required=%s", name, act, req);
    end
  endtask

  bit    active = 0;
  bit    rst_seen = 0;
  string os = "";
  string oi = "";

  always @(negedge clk) begin
    if (rst_seen)
      chk("reset_state",
          {tx, ponto, traco, elem_idx, done, err, in_ready} == 9'b1,
          $sformatf("%b", {tx, ponto, traco, elem_idx, done, err, in_ready}),
          "000000001");
    rst_seen = reset;
    if (reset) begin
      if (active && q.size() > 0) void'(q.pop_front());
      active = 0;
      os = "";
      oi = "";
    end else begin
      chk("strobes", ((ponto | traco) == tx) && !(ponto && traco),
          $sformatf("tx%b p%b t%b", tx, ponto, traco), "p|t==tx,!p&t");
      if (done || err) begin
        if (!active || q.size() == 0) begin
          chk("spurious", 1'b0, $sformatf("done%b err%b", done, err),
              "no pulse");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("kind", err == e.is_err, $sformatf("err%b", err),
              $sformatf("err%b", e.is_err));
          chk("marks", os == e.sym, os, e.sym);
          chk("elem_idx", oi == e.idx, oi, e.idx);
          if (err)
            chk("err_idle", !tx && in_ready && !done,
                $sformatf("tx%b rdy%b", tx, in_ready), "tx0 rdy1");
        end
        active = 0;
        os = "";
        oi = "";
      end else if (active) begin
        chk("busy", !in_ready, $sformatf("%b", in_ready), "0");
        os = {os, tx ? (ponto ? "." : "-") : "_"};
        oi = $sformatf("%s%0d", oi, elem_idx);
        if (os.len() > 400) begin
          chk("overrun", 1'b0, "no done", "done");
          if (q.size() > 0) void'(q.pop_front());
          active = 0;
          os = "";
          oi = "";
        end
      end
      if (in_valid && in_ready) active = 1;
    end
  end

  task automatic send(int c, bit hold);
    bit ok;
    ok = 0;
    num = 6'(c);
    in_valid = 1'b1;
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      if (in_ready && !reset) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 1'b0, "no in_ready", "in_ready");
      in_valid = 1'b0;
      return;
    end
    q.push_back(model(c));
    @(posedge clk);
    #2;
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    int order[38];
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    send(4, 0);
    send(0, 0);
    send(26, 0);
    send(19, 1);
    send(4, 0);
    send(50, 0);
    send(36, 0);
    send(0, 0);
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (traco) break;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    send(4, 0);
    for (int i = 0; i < 38; i++) order[i] = i;
    for (int i = 37; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 38; i++) send(order[i], 1'($urandom % 2));
    for (int i = 0; i < 15; i++) begin
      int c;
      c = ($urandom % 4 == 0) ? $urandom_range(36, 63)
                              : $urandom_range(0, 35);
      send(c, 1'($urandom % 2));
    end
    in_valid = 1'b0;
    for (int w = 0; w < 2000; w++) begin
      @(negedge clk);
      if (q.size() == 0 && !active) break;
    end
    chk("drain", q.size() == 0, $sformatf("%0d", q.size()), "0");
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
